// File: rtl/matrix_loader_if.sv
// Column-load port bundle between the matrix producer, the vertex issue/retire
// taps and the loader. The loader sits on the slave side.
interface matrix_loader_if;
   logic             word_valid_in;
   logic             word_ready_out;
   logic [31:0]      word_in;
   logic             vtx_issue_in;
   logic             vtx_retire_in;
   logic             vtx_hold_out;
   logic             col_set_out;
   logic [3:0][31:0] col_out;
   logic             load_done_out;
   logic             err_out;

   modport slave (
      input  word_valid_in, word_in, vtx_issue_in, vtx_retire_in,
      output word_ready_out, vtx_hold_out, col_set_out, col_out,
      load_done_out, err_out
   );

   modport master (
      output word_valid_in, word_in, vtx_issue_in, vtx_retire_in,
      input  word_ready_out, vtx_hold_out, col_set_out, col_out,
      load_done_out, err_out
   );
endinterface

// File: rtl/matrix_loader.sv
// Matrix loader: buffers a streamed 4x4 fp32 transform, holds off new vertices
// until the pipeline is empty, then writes the four columns to the shader.
// Optional build macro MATRIX_LOADER_TRANSPOSE_EN: accept row-major input.
//
// state | meaning
// FILL  | accepting the 16 matrix words
// DRAIN | vertices held off, waiting for in-flight count to reach zero
// EMIT  | four column strobes, c = 0..3
// DONE  | one-cycle completion pulse, then back to FILL
module matrix_loader #(
   parameter int CNT_W = 6
) (
   input logic            clk_in,
   input logic            rst_n_in,
   matrix_loader_if.slave bus
);
   typedef enum logic [1:0] {FILL, DRAIN, EMIT, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                 state_q, state_d;
   logic [3:0]             k_q, k_d;
   logic [1:0]             c_q, c_d;
   logic [3:0][3:0][31:0]  buf_q, buf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   ready_q, ready_d;
   logic                   hold_q, hold_d;
   logic                   col_set_q, col_set_d;
   logic [3:0][31:0]       col_q, col_d;
   logic                   load_done_q, load_done_d;
   logic [1:0]             wr_col, wr_row;

`ifdef MATRIX_LOADER_TRANSPOSE_EN
   assign wr_col = k_q[1:0];
   assign wr_row = k_q[3:2];
`else
   assign wr_col = k_q[3:2];
   assign wr_row = k_q[1:0];
`endif

   // Sequencing: word capture, drain wait and column walk.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      c_d     = c_q;
      buf_d   = buf_q;
      case (state_q)
         FILL: begin
            if (bus.word_valid_in) begin
               buf_d[wr_col][wr_row] = bus.word_in;
               k_d = k_q + 4'd1;
               if (k_q == 4'd15) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == '0 && !bus.vtx_issue_in) begin
               state_d = EMIT;
               c_d     = 2'd0;
            end
         end
         EMIT: begin
            c_d = c_q + 2'd1;
            if (c_q == 2'd3) state_d = DONE;
         end
         DONE: state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // Outputs are registered, so derive them from the next state.
   always_comb begin
      ready_d     = (state_d == FILL);
      hold_d      = (state_d != FILL);
      col_set_d   = (state_d == EMIT);
      load_done_d = (state_d == DONE);
      col_d       = col_q;
      if (state_d == EMIT) col_d = buf_q[c_d];
   end

   // In-flight vertex count, saturating at both ends with a sticky error.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (bus.vtx_issue_in && !bus.vtx_retire_in) begin
         if (cnt_q == CNT_MAX) err_d = 1'b1;
         else                  cnt_d = cnt_q + 1'b1;
      end else if (bus.vtx_retire_in && !bus.vtx_issue_in) begin
         if (cnt_q == '0) err_d = 1'b1;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   // State, buffer, counter and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= FILL;
         k_q         <= '0;
         c_q         <= '0;
         buf_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ready_q     <= 1'b1;
         hold_q      <= 1'b0;
         col_set_q   <= 1'b0;
         col_q       <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         c_q         <= c_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         hold_q      <= hold_d;
         col_set_q   <= col_set_d;
         col_q       <= col_d;
         load_done_q <= load_done_d;
      end
   end

   assign bus.word_ready_out = ready_q;
   assign bus.vtx_hold_out   = hold_q;
   assign bus.col_set_out    = col_set_q;
   assign bus.col_out        = col_q;
   assign bus.load_done_out  = load_done_q;
   assign bus.err_out        = err_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: table of directed loads, randomized loads against a
// transaction-level model, and hand-written reset / error sequences.
module tb_matrix_loader;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
   localparam logic [31:0] C12 = 32'h40000009;
`else
   localparam logic [31:0] C12 = 32'h40000006;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   matrix_loader_if bus_if();
   matrix_loader #(.CNT_W(CNT_W)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_if));

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   m_cnt = 0;
   bit   m_err = 1'b0;
   logic [31:0] cur_w [16];

   typedef struct {
      int          pat;
      int          n_pre;
      bit          iss_last;
      int          mode;
      int          d;
      int          exp_gap;
      logic [31:0] exp_c12;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive vertex taps for the coming edge and advance the count model.
   task automatic drive(input bit iss, input bit ret);
      bus_if.vtx_issue_in  = iss;
      bus_if.vtx_retire_in = ret;
      if (iss && !ret) begin
         if (m_cnt == CNT_MAX) m_err = 1'b1;
         else                  m_cnt++;
      end else if (ret && !iss) begin
         if (m_cnt == 0) m_err = 1'b1;
         else            m_cnt--;
      end
   endtask

   function automatic logic [127:0] exp_col(input int c);
      logic [3:0][31:0] e;
      for (int r = 0; r < 4; r++) begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
         e[r] = cur_w[r*4 + c];
`else
         e[r] = cur_w[c*4 + r];
`endif
      end
      return e;
   endfunction

   task automatic fill_words(input int pat);
      for (int k = 0; k < 16; k++) begin
         case (pat)
            0:       cur_w[k] = (k % 5 == 0) ? 32'h3F800000 : 32'h0;
            1:       cur_w[k] = 32'h40000000 + k;
            default: cur_w[k] = $urandom;
         endcase
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus_if.word_valid_in = 1'b0;
      bus_if.word_in       = '0;
      bus_if.vtx_issue_in  = 1'b0;
      bus_if.vtx_retire_in = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // One full load. exp_gap > 0 fixes the first strobe cycle relative to the
   // word-15 cycle; exp_gap == 0 lets the count model decide.
   // mode 0: retire one per cycle once more than d cycles into drain
   // mode 1: random issue/retire; mode 2: issue+retire together, then a lone retire
   task automatic run_load(input int n_pre, input bit iss_last, input int mode, input int d,
                           input int exp_gap, input bit chk12, input logic [31:0] exp_c12);
      int n;
      int k;
      bit iss, ret, emit_next, reached;
      for (int i = 0; i < n_pre; i++) begin
         drive(1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0);
      for (int w = 0; w < 16; w++) begin
         chk("word_ready", bus_if.word_ready_out, 1'b1);
         bus_if.word_valid_in = 1'b1;
         bus_if.word_in       = cur_w[w];
         if (w == 15) begin
            n = cyc;
            drive(iss_last, 1'b0);
         end else begin
            drive(1'b0, 1'b0);
         end
         tick();
      end
      bus_if.word_valid_in = 1'b0;
      bus_if.word_in       = '0;
      reached = 1'b0;
      for (int it = 0; it < 300; it++) begin
         chk("drain_hold_ready_colset", {bus_if.vtx_hold_out, bus_if.word_ready_out, bus_if.col_set_out}, 3'b100);
         k = cyc - n;
         iss = 1'b0;
         ret = 1'b0;
         case (mode)
            0: ret = (k > d) && (m_cnt > 0);
            1: begin
               if (it < 40) begin
                  iss = ($urandom_range(0, 3) == 0);
                  ret = ($urandom_range(0, 1) == 1) && (m_cnt > 0 || iss);
               end else begin
                  ret = (m_cnt > 0);
               end
            end
            default: begin
               iss = (k == 1);
               ret = (k == 1) || (k == 3);
            end
         endcase
         emit_next = (m_cnt == 0) && !iss;
         drive(iss, ret);
         tick();
         if (exp_gap > 0 ? ((cyc - n) >= exp_gap) : emit_next) begin
            reached = 1'b1;
            break;
         end
      end
      drive(1'b0, 1'b0);
      if (!reached) begin
         chk("drain_timeout", 1'b0, 1'b1);
         return;
      end
      for (int c = 0; c < 4; c++) begin
         chk("col_set_high", bus_if.col_set_out, 1'b1);
         chk("col_data", bus_if.col_out, exp_col(c));
         if (c == 1 && chk12) chk("col1_row2", bus_if.col_out[2], exp_c12);
         tick();
      end
      chk("done_pulse", {bus_if.col_set_out, bus_if.load_done_out}, 2'b01);
      tick();
      chk("back_to_fill", {bus_if.vtx_hold_out, bus_if.word_ready_out, bus_if.load_done_out}, 3'b010);
      chk("err_track", bus_if.err_out, m_err);
   endtask

   initial begin
      vecs[0] = '{0, 0, 1'b0, 0, 0, 2, 32'h0};
      vecs[1] = '{1, 3, 1'b0, 0, 0, 5, C12};
      vecs[2] = '{1, 3, 1'b0, 0, 2, 7, C12};
      vecs[3] = '{0, 1, 1'b0, 2, 0, 5, 32'h0};
      vecs[4] = '{1, 0, 1'b1, 0, 0, 3, C12};
      vecs[5] = '{1, 0, 1'b0, 0, 0, 2, C12};

      bus_if.word_valid_in = 1'b0;
      bus_if.word_in       = '0;
      bus_if.vtx_issue_in  = 1'b0;
      bus_if.vtx_retire_in = 1'b0;
      #12;
      chk("reset_flags", {bus_if.word_ready_out, bus_if.vtx_hold_out, bus_if.col_set_out,
                          bus_if.load_done_out, bus_if.err_out}, 5'b10000);
      chk("reset_col", bus_if.col_out, 128'h0);
      apply_reset();

      for (int v = 0; v < 6; v++) begin
         fill_words(vecs[v].pat);
         run_load(vecs[v].n_pre, vecs[v].iss_last, vecs[v].mode, vecs[v].d,
                  vecs[v].exp_gap, 1'b1, vecs[v].exp_c12);
      end

      for (int r = 0; r < 8; r++) begin
         fill_words(2);
         run_load($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1, 0, 0, 1'b0, 32'h0);
      end

      // Saturation at the top of the count.
      apply_reset();
      for (int i = 0; i < CNT_MAX; i++) begin
         drive(1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0);
      tick();
      chk("err_before_sat", bus_if.err_out, 1'b0);
      drive(1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0);
      tick();
      chk("err_on_sat", bus_if.err_out, 1'b1);
      for (int i = 0; i < CNT_MAX; i++) begin
         drive(1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0);
      fill_words(1);
      run_load(0, 1'b0, 0, 0, 2, 1'b1, C12);

      // Retire at zero: sticky error across a load, cleared by reset.
      apply_reset();
      drive(1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0);
      chk("err_underflow", bus_if.err_out, 1'b1);
      fill_words(0);
      run_load(2, 1'b0, 0, 1, 5, 1'b1, 32'h0);
      chk("err_sticky", bus_if.err_out, 1'b1);
      apply_reset();
      chk("err_cleared", bus_if.err_out, 1'b0);

      // Reset mid-fill: partial words are discarded.
      fill_words(2);
      for (int w = 0; w < 7; w++) begin
         bus_if.word_valid_in = 1'b1;
         bus_if.word_in       = cur_w[w];
         tick();
      end
      apply_reset();
      fill_words(1);
      run_load(0, 1'b0, 0, 0, 2, 1'b1, C12);

      // Asynchronous reset after two strobes, then a clean full load.
      fill_words(2);
      for (int w = 0; w < 16; w++) begin
         bus_if.word_valid_in = 1'b1;
         bus_if.word_in       = cur_w[w];
         tick();
      end
      bus_if.word_valid_in = 1'b0;
      tick();
      chk("abort_strobe0", bus_if.col_set_out, 1'b1);
      tick();
      chk("abort_strobe1", bus_if.col_set_out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_flags", {bus_if.word_ready_out, bus_if.vtx_hold_out, bus_if.col_set_out,
                                bus_if.load_done_out, bus_if.err_out}, 5'b10000);
      chk("async_reset_col", bus_if.col_out, 128'h0);
      m_cnt = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      fill_words(1);
      run_load(0, 1'b0, 0, 0, 2, 1'b1, C12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Producer side of the vertex shader's column-load port. Accepts a 4x4 fp32 transform as 16 streamed words and buffers it. It then holds off new vertices and waits until every vertex already in the transform pipeline has retired. Finally it emits the four `col_set`/`col` writes the shader expects, in column order 0..3, so a matrix change never lands on a vertex in flight.

## Interface

Parameters:
- `CNT_W`, default 6: width of the in-flight vertex counter; supports up to 2^CNT_W−1 outstanding vertices.

Ports:
- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `word_valid_in`  in  1  matrix word available.
- `word_ready_out`  out  1  loader accepts a word; transfer when valid && ready.
- `word_in`  in  32  fp32 matrix element, column-major: word k is column k/4, row k%4.
- `vtx_issue_in`  in  1  one vertex entered the shader this cycle (shader `valid_in`).
- `vtx_retire_in`  in  1  one vertex left the shader this cycle (shader `valid_out`).
- `vtx_hold_out`  out  1  upstream must not issue vertices while high.
- `col_set_out`  out  1  column write strobe to the shader.
- `col_out`  out  4x32  column data; `col_out[i]` is row i.
- `load_done_out`  out  1  one-cycle pulse after the 4th column write.
- `err_out`  out  1  sticky in-flight counter over/underflow flag.

## Operation

- FSM states are FILL, DRAIN, EMIT and DONE. Reset enters FILL.
- FILL:
  - `word_ready_out`=1.
  - Each accepted word is written to buffer slot [k/4][k%4], and word index k increments.
  - On acceptance of word 15, k wraps to 0 and the FSM goes to DRAIN.
- DRAIN:
  - `word_ready_out`=0 and `vtx_hold_out`=1.
  - Go to EMIT when the in-flight count is 0 and `vtx_issue_in`=0 in the same cycle.
- EMIT:
  - Runs for exactly 4 consecutive cycles, with column index c = 0,1,2,3.
  - `col_set_out`=1 and `col_out`=buffer[c].
  - After c=3, go to DONE.
- DONE:
  - Lasts 1 cycle with `load_done_out`=1, then returns to FILL.
  - `vtx_hold_out` falls and `word_ready_out` rises on entry to FILL.
- In-flight counter:
  - issue only: +1.
  - retire only: −1.
  - both in the same cycle: unchanged.
  - Counting is active in every state.
- Counter boundaries:
  - Retire at count 0: count stays 0 and `err_out` is set.
  - Issue at count 2^CNT_W−1: count saturates and `err_out` is set.
  - `err_out` clears only on reset.
- The shader's column index advances on every strobe. The loader therefore always issues exactly 4 strobes per load, never fewer or more. The loader and the shader must share reset.
- Reset mid-operation:
  - Returns the loader to FILL and clears the buffer index, counter and outputs.
  - Partially received words are discarded.

## Timing

- All outputs are registered. Reset values:
  - `word_ready_out`=1.
  - `vtx_hold_out`=0, `col_set_out`=0, `col_out`=0, `load_done_out`=0, `err_out`=0.
- If word 15 is accepted in cycle N:
  - DRAIN is entered at N+1, and `vtx_hold_out`=1 from N+1.
  - An issue in cycle N is still counted.
- With an empty pipeline and no issue at N+1:
  - `col_set_out` is high N+2..N+5.
  - `load_done_out` pulses at N+6.
  - `vtx_hold_out`=0 and `word_ready_out`=1 at N+7.
- Drain wait is data-dependent: at least one cycle after the last retire brings the count to 0.
- Minimum back-to-back load period: 16 fill + 1 drain + 4 emit + 1 done = 22 cycles.

## Configuration

- `MATRIX_LOADER_TRANSPOSE_EN`
  - Defined: input is row-major; word k goes to buffer slot [k%4][k/4], i.e. column k%4, row k/4.
  - Undefined: column-major as above.
- Handshake, timing and emit order are identical in both builds.

## Test plan

- Reset, then stream 16 words 0x3F800000·(k%5==0) (identity), no vertices -> `col_set_out` high 4 cycles starting 2 cycles after word 15. `col_out[c][c]`=0x3F800000, all other elements 0. `load_done_out` pulses once.
- Stream 16 words 0x40000000+k, with 3 vertices issued earlier and not yet retired -> `vtx_hold_out`=1 and no `col_set_out` until the 3rd retire. Strobes begin 1 cycle after the count hits 0. `col_out[1][2]`=0x40000006.
- Issue and retire in the same cycle while in DRAIN at count 1 -> count stays 1 and EMIT is not entered until a lone retire.
- Retire with count 0 -> `err_out`=1 and stays 1 through subsequent loads until `rst_n_in` low.
- Assert `rst_n_in` low during EMIT after 2 strobes -> all outputs at reset values immediately (asynchronous). A following full load produces exactly 4 strobes.
- With `MATRIX_LOADER_TRANSPOSE_EN`, words 0x40000000+k -> `col_out[1][2]`=0x40000009.
